// File: rtl/result_display_seq_pkg.sv
// Shared systolic-array display definitions: result modes, display FSM states
// and the fixed element count of each array mode.
package result_display_seq_pkg;

    typedef enum logic [1:0] {
        MODE_PE     = 2'd0,
        MODE_SA2X2  = 2'd1,
        MODE_SA3X3  = 2'd2,
        MODE_CUSTOM = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        CAPT  = 3'd2,
        DWELL = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam int unsigned PE_ELEMS    = 1;
    localparam int unsigned SA2X2_ELEMS = 4;
    localparam int unsigned SA3X3_ELEMS = 9;

endpackage

// File: rtl/result_display_seq_dwell.sv
// Down-counter timing how long each element stays on the display.
module dwell_timer #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             enable,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (enable && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/result_display_seq.sv
// Steps through the result elements of a PE or systolic-array run, holding each
// one on display_out for a programmable dwell time.
module result_display_seq
    import result_display_seq_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_ELEM  = 16,
    parameter int unsigned DWELL_CYC = 4,
    localparam int unsigned SEL_W    = $clog2(MAX_ELEM)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              display_on,
    input  logic [1:0]        mode,
    input  logic [SEL_W:0]    elem_count,
    input  logic              hold,
    input  logic [DATA_W-1:0] c,
    output logic [SEL_W-1:0]  c_select_o,
    output logic [DATA_W-1:0] display_out,
    output logic              display_valid_o,
    output logic              done_display_o,
    output logic              PE_result,
    output logic              SA_2x2_result,
    output logic              SA_3x3_result
);

    localparam int unsigned  CNT_W = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
    localparam logic [SEL_W:0] N_MAX = (SEL_W+1)'(MAX_ELEM);

    state_e         state_q, state_d;
    logic [SEL_W:0] n_q, n_raw, n_start;
    logic           on_low_q;
    logic           start, capt, advance, abort;
    logic           last_elem, tmr_zero, tmr_enable;

    // on_low_q means "display_on was low last cycle"; resetting it to 0 keeps a
    // display_on held high through reset from looking like a fresh edge.
    assign start = (state_q == IDLE) && display_on && on_low_q;

    always_comb begin
        n_raw = elem_count;
        case (mode_e'(mode))
            MODE_PE:    n_raw = (SEL_W+1)'(PE_ELEMS);
            MODE_SA2X2: n_raw = (SEL_W+1)'(SA2X2_ELEMS);
            MODE_SA3X3: n_raw = (SEL_W+1)'(SA3X3_ELEMS);
            default:    n_raw = elem_count;
        endcase
        n_start = (n_raw > N_MAX) ? N_MAX : n_raw;
    end

    assign last_elem = ({1'b0, c_select_o} == (n_q - (SEL_W+1)'(1)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        capt    = 1'b0;
        advance = 1'b0;
        abort   = 1'b0;
        case (state_q)
            IDLE:    if (start) state_d = (n_start == '0) ? DONE : ADDR;
            ADDR:    state_d = CAPT;
            CAPT:    begin
                capt    = 1'b1;
                state_d = DWELL;
            end
            DWELL:   if (!hold && tmr_zero) begin
                if (last_elem) begin
                    state_d = DONE;
                end else begin
                    advance = 1'b1;
                    state_d = ADDR;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Dropping display_on mid-run overrides every transition, including
        // the one into DONE, so an aborted run never pulses done.
        if ((state_q != IDLE) && (state_q != DONE) && !display_on) begin
            abort   = 1'b1;
            capt    = 1'b0;
            advance = 1'b0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            on_low_q        <= 1'b0;
            n_q             <= '0;
            c_select_o      <= '0;
            display_out     <= '0;
            display_valid_o <= 1'b0;
            PE_result       <= 1'b0;
            SA_2x2_result   <= 1'b0;
            SA_3x3_result   <= 1'b0;
        end else begin
            on_low_q <= ~display_on;
            if (start) begin
                n_q             <= n_start;
                c_select_o      <= '0;
                display_valid_o <= 1'b0;
                PE_result       <= (mode_e'(mode) == MODE_PE);
                SA_2x2_result   <= (mode_e'(mode) == MODE_SA2X2);
                SA_3x3_result   <= (mode_e'(mode) == MODE_SA3X3);
            end
            if (capt) begin
                display_out     <= c;
                display_valid_o <= 1'b1;
            end
            if (advance) begin
                c_select_o <= c_select_o + SEL_W'(1);
            end
            if (abort) begin
                c_select_o      <= '0;
                display_valid_o <= 1'b0;
            end
        end
    end

    assign tmr_enable     = (state_q == DWELL) && !hold;
    assign done_display_o = (state_q == DONE);

    dwell_timer #(
        .CNT_W (CNT_W)
    ) u_dwell_timer (
        .clk      (clk),
        .rst_n    (reset),
        .load     (capt),
        .load_val (CNT_W'(DWELL_CYC - 1)),
        .enable   (tmr_enable),
        .zero     (tmr_zero)
    );

endmodule

// File: tb/tb_result_display_seq.sv
// Directed bench for result_display_seq: per-cycle timeline expectations for
// each display scenario, plus reset behaviour.
module tb_result_display_seq;

    localparam int DATA_W    = 8;
    localparam int MAX_ELEM  = 16;
    localparam int DWELL_CYC = 4;
    localparam int SEL_W     = $clog2(MAX_ELEM);

    logic              clk = 1'b0;
    logic              reset;
    logic              display_on;
    logic [1:0]        mode;
    logic [SEL_W:0]    elem_count;
    logic              hold;
    logic [DATA_W-1:0] c;
    logic [SEL_W-1:0]  c_select_o;
    logic [DATA_W-1:0] display_out;
    logic              display_valid_o;
    logic              done_display_o;
    logic              PE_result;
    logic              SA_2x2_result;
    logic              SA_3x3_result;

    logic [DATA_W-1:0] data_tab [MAX_ELEM];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Result memory: c follows c_select_o, settled well before the capture edge.
    assign c = data_tab[c_select_o];

    result_display_seq #(
        .DATA_W    (DATA_W),
        .MAX_ELEM  (MAX_ELEM),
        .DWELL_CYC (DWELL_CYC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .display_on      (display_on),
        .mode            (mode),
        .elem_count      (elem_count),
        .hold            (hold),
        .c               (c),
        .c_select_o      (c_select_o),
        .display_out     (display_out),
        .display_valid_o (display_valid_o),
        .done_display_o  (done_display_o),
        .PE_result       (PE_result),
        .SA_2x2_result   (SA_2x2_result),
        .SA_3x3_result   (SA_3x3_result)
    );

    task automatic fill_data(input int kind);
        for (int i = 0; i < MAX_ELEM; i++) begin
            case (kind)
                0:       data_tab[i] = (i == 0) ? 8'h5A : 8'h00;
                1:       data_tab[i] = DATA_W'(i * 3);
                2:       data_tab[i] = DATA_W'(8'h11 * (i + 1));
                default: data_tab[i] = DATA_W'(8'h80 + i);
            endcase
        end
    endtask

    // Element i occupies ADDR, CAPT, then DWELL_CYC (+hold) cycles; cycle 1 is
    // the cycle after the start edge, and done follows the last element.
    task automatic run_check(input logic [1:0] m, input int ec, input int n,
                             input int hold_elem, input int hold_len,
                             input int abort_elem, input int exp_done_cyc,
                             input logic [2:0] exp_flags, input int keep_high,
                             input string name);
        int first_done, s, i, ph, len;
        bit in_elem, aborted, chk_out;
        logic [SEL_W-1:0]  e_sel;
        logic              e_valid, e_done;
        logic [DATA_W-1:0] e_out;
        @(negedge clk);
        mode       = m;
        elem_count = ec[SEL_W:0];
        hold       = 1'b0;
        display_on = 1'b1;
        first_done = 0;
        aborted    = 0;
        for (int cyc = 1; cyc <= exp_done_cyc && !aborted; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 1) begin
                mode       = ~m;
                elem_count = (SEL_W+1)'(2);
            end
            s = 1; in_elem = 0; i = 0; ph = 0;
            for (int k = 0; k < n; k++) begin
                len = DWELL_CYC + ((k == hold_elem) ? hold_len : 0);
                if (!in_elem) begin
                    if (cyc < s + 2 + len) begin
                        in_elem = 1; i = k; ph = cyc - s;
                    end else begin
                        s += 2 + len;
                    end
                end
            end
            if (in_elem) begin
                e_sel   = SEL_W'(i);
                e_done  = 1'b0;
                e_valid = (ph >= 2) || (i > 0);
                chk_out = (ph >= 2);
                e_out   = data_tab[i];
            end else begin
                e_sel   = (n > 0) ? SEL_W'(n - 1) : '0;
                e_done  = (cyc == s);
                e_valid = (n > 0);
                chk_out = (n > 0);
                e_out   = (n > 0) ? data_tab[n - 1] : '0;
            end
            checks++;
            if (c_select_o !== e_sel) begin
                failures++;
                $display("FAIL %s sel cyc=%0d got=%0d exp=%0d", name, cyc, c_select_o, e_sel);
            end
            checks++;
            if (display_valid_o !== e_valid) begin
                failures++;
                $display("FAIL %s valid cyc=%0d got=%b exp=%b", name, cyc, display_valid_o, e_valid);
            end
            checks++;
            if (done_display_o !== e_done) begin
                failures++;
                $display("FAIL %s done cyc=%0d got=%b exp=%b", name, cyc, done_display_o, e_done);
            end
            if (chk_out) begin
                checks++;
                if (display_out !== e_out) begin
                    failures++;
                    $display("FAIL %s out cyc=%0d got=%h exp=%h", name, cyc, display_out, e_out);
                end
            end
            if (cyc == 1 || e_done) begin
                checks++;
                if ({PE_result, SA_2x2_result, SA_3x3_result} !== exp_flags) begin
                    failures++;
                    $display("FAIL %s flags cyc=%0d got=%b exp=%b", name, cyc,
                             {PE_result, SA_2x2_result, SA_3x3_result}, exp_flags);
                end
            end
            if (done_display_o === 1'b1 && first_done == 0) first_done = cyc;
            hold = in_elem && (i == hold_elem) && (ph >= 2) && (ph < 2 + hold_len);
            if (in_elem && i == abort_elem && ph == 2) begin
                display_on = 1'b0;
                aborted    = 1;
            end
        end
        hold = 1'b0;
        if (aborted) begin
            repeat (4) begin
                @(posedge clk);
                #1;
                checks++;
                if (display_valid_o !== 1'b0 || done_display_o !== 1'b0) begin
                    failures++;
                    $display("FAIL %s abort got valid=%b done=%b exp valid=0 done=0",
                             name, display_valid_o, done_display_o);
                end
            end
        end else begin
            checks++;
            if (first_done !== exp_done_cyc) begin
                failures++;
                $display("FAIL %s done_cycle got=%0d exp=%0d", name, first_done, exp_done_cyc);
            end
            e_sel = (n > 0) ? SEL_W'(n - 1) : '0;
            repeat (keep_high) begin
                @(posedge clk);
                #1;
                checks++;
                if (done_display_o !== 1'b0 || c_select_o !== e_sel) begin
                    failures++;
                    $display("FAIL %s no_restart got done=%b sel=%0d exp done=0 sel=%0d",
                             name, done_display_o, c_select_o, e_sel);
                end
            end
            @(negedge clk);
            display_on = 1'b0;
            repeat (2) @(posedge clk);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({c_select_o, display_out, display_valid_o, done_display_o,
             PE_result, SA_2x2_result, SA_3x3_result} !== '0) begin
            failures++;
            $display("FAIL %s got sel=%0d out=%h valid=%b done=%b flags=%b exp all 0", name,
                     c_select_o, display_out, display_valid_o, done_display_o,
                     {PE_result, SA_2x2_result, SA_3x3_result});
        end
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        display_on = 1'b0;
        hold       = 1'b0;
        mode       = 2'd0;
        elem_count = '0;
        fill_data(0);
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_pe_mode();
        fill_data(0);
        run_check(2'd0, 0, 1, -1, 0, -1, 7, 3'b100, 3, "pe");
    endtask

    task automatic test_sa3x3();
        fill_data(1);
        run_check(2'd2, 0, 9, -1, 0, -1, 55, 3'b001, 5, "sa3x3");
    endtask

    task automatic test_hold();
        fill_data(2);
        run_check(2'd1, 0, 4, 2, 5, -1, 30, 3'b010, 0, "hold");
    endtask

    task automatic test_abort();
        fill_data(1);
        run_check(2'd2, 0, 9, -1, 0, 4, 200, 3'b001, 0, "abort");
        run_check(2'd2, 0, 9, -1, 0, -1, 55, 3'b001, 0, "restart");
    endtask

    task automatic test_custom();
        fill_data(3);
        run_check(2'd3, 0, 0, -1, 0, -1, 1, 3'b000, 0, "n_zero");
        run_check(2'd3, MAX_ELEM + 3, MAX_ELEM, -1, 0, -1, 97, 3'b000, 0, "clamp");
    endtask

    task automatic test_reset_mid_run();
        fill_data(2);
        @(negedge clk);
        mode       = 2'd1;
        display_on = 1'b1;
        repeat (21) @(posedge clk);
        #1;
        checks++;
        if (display_out !== 8'h44 || display_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL mid_run_elem3 got out=%h valid=%b exp out=44 valid=1",
                     display_out, display_valid_o);
        end
        #1;
        reset = 1'b0;
        #1;
        check_all_zero("reset_async");
        @(negedge clk);
        reset = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            check_all_zero("no_start_after_reset");
        end
        @(negedge clk);
        display_on = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_pe_mode();
        test_sa3x3();
        test_hold();
        test_abort();
        test_custom();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/result_display_seq.md
RESULT_DISPLAY_SEQ -- requirements
Module: result_display_seq

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning result element width in bits.
REQ-002 The block SHALL have parameter MAX_ELEM, default 16, meaning maximum elements per display run; SEL_W = clog2(MAX_ELEM).
REQ-003 The block SHALL have parameter DWELL_CYC, default 4, meaning cycles each element is held on display_out; legal values are 1 or more.
REQ-004 The block SHALL have port clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, width 1: asynchronous, active-low reset.
REQ-006 The block SHALL have port display_on, input, width 1: high while the controller is in its display state; a rising edge starts a run.
REQ-007 The block SHALL have port mode, input, width 2: 0 = PE (1 element), 1 = SA 2x2 (4 elements), 2 = SA 3x3 (9 elements), 3 = custom (elem_count elements).
REQ-008 The block SHALL have port elem_count, input, width SEL_W+1: element count for mode 3.
REQ-009 The block SHALL have port hold, input, width 1: freezes the dwell counter while high.
REQ-010 The block SHALL have port c, input, width DATA_W: result element at index c_select_o, valid one cycle after c_select_o changes.
REQ-011 The block SHALL have port c_select_o, output, width SEL_W: result element index.
REQ-012 The block SHALL have port display_out, output, width DATA_W: displayed element.
REQ-013 The block SHALL have port display_valid_o, output, width 1: display_out holds a captured element.
REQ-014 The block SHALL have port done_display_o, output, width 1: one-cycle pulse at run completion.
REQ-015 The block SHALL have ports PE_result, SA_2x2_result and SA_3x3_result, outputs, width 1 each: one-hot flags for the mode latched for the current run.

Function
REQ-016 The block SHALL implement states IDLE, ADDR, CAPT, DWELL, DONE.
REQ-017 IDLE SHALL move to ADDR on a display_on rising edge, latching mode and the element count N (1/4/9/elem_count) and setting c_select_o to 0.
REQ-018 ADDR SHALL last exactly one cycle, covering the read latency, then move to CAPT.
REQ-019 CAPT SHALL register c into display_out, set display_valid_o and load the dwell counter with DWELL_CYC-1, then move to DWELL.
REQ-020 DWELL SHALL decrement the counter each cycle hold is low and keep it unchanged while hold is high.
REQ-021 At counter 0 with hold low, DWELL SHALL increment c_select_o and go to ADDR if the index is below N-1, otherwise go to DONE.
REQ-022 DONE SHALL assert done_display_o for exactly one cycle, keep display_out and display_valid_o at the last element, then return to IDLE.
REQ-023 A run SHALL start only on a new rising edge of display_on; holding display_on high after DONE SHALL NOT restart a run.
REQ-024 If display_on falls in any non-IDLE state, the block SHALL return to IDLE next cycle, clear display_valid_o and not pulse done_display_o.
REQ-025 If latched N is 0, the run SHALL go IDLE -> DONE directly, pulse done_display_o, and keep display_valid_o low.
REQ-026 If latched N exceeds MAX_ELEM, N SHALL be clamped to MAX_ELEM.
REQ-027 The mode flags SHALL stay set from run start until the next run start, and all three SHALL be low in mode 3.
REQ-028 Changes to mode or elem_count during a run SHALL have no effect.
REQ-029 c_select_o SHALL never exceed N-1 and SHALL never wrap.
REQ-030 Each element SHALL stay on display_out for DWELL_CYC cycles plus the number of hold-high cycles; a run SHALL take N*(DWELL_CYC+2)+1 cycles from the start edge to the done pulse when hold stays low.

Reset
REQ-031 Reset low SHALL force, asynchronously: state IDLE; c_select_o 0; display_out 0; display_valid_o 0; done_display_o 0; all mode flags 0; dwell counter 0; display_on edge register 0.
REQ-032 Reset asserted mid-run SHALL abort the run without a done pulse, and after release a new display_on rising edge SHALL be needed to start.

Structure
REQ-033 The mode encodings, state encoding and the per-mode element counts (1, 4, 9) SHALL live in the shared systolic-array package.
REQ-034 The dwell counter SHALL be a sub-module named dwell_timer with load, enable and zero outputs; everything else SHALL stay in one FSM module.

Verification
REQ-035 Mode 0, DWELL_CYC=4, c=0x5A -> display_out 0x5A for 4 cycles, done pulse at cycle 7, PE_result 1.
REQ-036 Mode 2, c = index*3 -> c_select_o steps 0..8, display_out shows 0,3,...,24, done pulse at cycle 55, SA_3x3_result 1.
REQ-037 Mode 1 with hold high for 5 cycles during element 2 -> element 2 stays for 9 cycles, done is delayed by 5 cycles.
REQ-038 Mode 2 with display_on dropped at element 4 -> IDLE next cycle, display_valid_o 0, no done pulse; the next rising edge restarts at index 0.
REQ-039 Mode 3 with elem_count=0 -> done pulse with display_valid_o staying 0; with elem_count=MAX_ELEM+3, exactly MAX_ELEM elements are shown.
REQ-040 Reset pulsed low at element 3 of mode 1 -> all outputs 0 immediately, and no run starts while display_on stays high after reset release.
